// File: rtl/hist_pkg.sv
// Shared types and constants for the histogram BRAM scheduler.
// Included by the request FIFO and the scheduler top.
package hist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        CLEAR,
        DONE_WR,
        FINISHED
    } state_t;

    localparam logic [3:0] WE_ALL      = 4'b1111;
    localparam int         BIN_TO_ADDR = 2;

endpackage

// File: rtl/hist_req_fifo.sv
// Small synchronous request FIFO holding clamped histogram bins.
// No push-to-pop bypass; flush empties it in one cycle.
module hist_req_fifo
    import hist_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push) r_wptr <= r_wptr + 1'b1;
            if (pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    assign dout  = r_mem[r_rptr[AW-1:0]];
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/histogram_bram_scheduler.sv
// Owns the histogram BRAM port: serialised read-modify-write increments,
// clear sweep on command and the end-of-run done marker.
module histogram_bram_scheduler
    import hist_pkg::*;
#(
    parameter int          NUM_BINS   = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] DONE_VALUE = 32'hffffffff
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_bin,
    input  logic        clear_start,
    output logic        clear_busy,
    input  logic        finish,
    output logic        done_written,
    output logic [31:0] clamp_count,
    output logic [3:0]  we,
    output logic        en,
    output logic [31:0] addr,
    output logic [31:0] di,
    input  logic [31:0] dout
);

    localparam int BW = $clog2(NUM_BINS);
    localparam logic [BW-1:0] LAST_BIN = BW'(NUM_BINS - 1);

    state_t         r_state;
    state_t         w_next;
    logic [BW-1:0]  r_cur_bin;
    logic [BW-1:0]  r_cnt;
    logic [31:0]    r_old_val;
    logic [31:0]    r_clamp_count;
    logic           r_fin_pend;
    logic           r_done;

    logic           w_clamp;
    logic [BW-1:0]  w_bin;
    logic           w_push;
    logic           w_pop;
    logic           w_clear_go;
    logic           w_full;
    logic           w_empty;
    logic [BW-1:0]  w_head;
    logic [31:0]    w_cur_addr;

    assign w_clamp    = (upd_bin >= 32'(NUM_BINS));
    assign w_bin      = w_clamp ? LAST_BIN : upd_bin[BW-1:0];
    assign w_push     = upd_valid && upd_ready;
    assign w_clear_go = clear_start &&
                        (r_state == IDLE || r_state == FINISHED);
    assign w_pop      = (r_state == IDLE) && !clear_start && !w_empty;
    assign w_cur_addr = 32'(r_cur_bin) << BIN_TO_ADDR;

    assign upd_ready    = reset_n && !w_full &&
                          (r_state != CLEAR) && (r_state != FINISHED);
    assign clear_busy   = (r_state == CLEAR);
    assign done_written = r_done;
    assign clamp_count  = r_clamp_count;

    hist_req_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .flush (w_clear_go),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_bin),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_next = r_state;
        en     = 1'b0;
        we     = 4'b0000;
        addr   = '0;
        di     = '0;
        unique case (r_state)
            IDLE: begin
                if (clear_start)     w_next = CLEAR;
                else if (!w_empty)   w_next = RD;
                else if (r_fin_pend) w_next = DONE_WR;
            end
            RD, CAP: begin
                en     = 1'b1;
                addr   = w_cur_addr;
                w_next = (r_state == RD) ? CAP : WR;
            end
            WR: begin
                en     = 1'b1;
                we     = WE_ALL;
                addr   = w_cur_addr;
                di     = (r_old_val == 32'hffffffff) ?
                         r_old_val : r_old_val + 32'd1;
                w_next = IDLE;
            end
            CLEAR: begin
                en   = 1'b1;
                we   = WE_ALL;
                addr = 32'(r_cnt) << BIN_TO_ADDR;
                if (r_cnt == LAST_BIN) w_next = IDLE;
            end
            DONE_WR: begin
                en     = 1'b1;
                we     = WE_ALL;
                addr   = 32'(NUM_BINS) << BIN_TO_ADDR;
                di     = DONE_VALUE;
                w_next = FINISHED;
            end
            FINISHED: begin
                if (clear_start) w_next = CLEAR;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cur_bin     <= '0;
            r_cnt         <= '0;
            r_old_val     <= '0;
            r_clamp_count <= '0;
            r_fin_pend    <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push && w_clamp) r_clamp_count <= r_clamp_count + 32'd1;
            if (w_pop)             r_cur_bin     <= w_head;
            if (r_state == CAP)    r_old_val     <= dout;
            if (r_state == CLEAR)  r_cnt         <= r_cnt + 1'b1;
            // A clear accepted in the same cycle as finish discards it.
            if (w_clear_go) begin
                r_cnt      <= '0;
                r_fin_pend <= 1'b0;
                r_done     <= 1'b0;
            end else if (r_state == DONE_WR) begin
                r_fin_pend <= 1'b0;
                r_done     <= 1'b1;
            end else if (finish && r_state != FINISHED) begin
                r_fin_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_histogram_bram_scheduler.sv
// Self-checking bench for histogram_bram_scheduler with a BRAM model
// and a bin-count reference histogram.
module tb_histogram_bram_scheduler;

    localparam int NB = 1024;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic [31:0] upd_bin = '0;
    logic        clear_start = 1'b0;
    logic        finish = 1'b0;
    logic        upd_ready;
    logic        clear_busy;
    logic        done_written;
    logic [31:0] clamp_count;
    logic [3:0]  we;
    logic        en;
    logic [31:0] addr;
    logic [31:0] di;
    logic [31:0] dout_r = '0;

    int total = 0;
    int bad = 0;

    logic [31:0] mem [0:NB] = '{default: '0};
    int          wr_cnt [0:NB] = '{default: 0};
    int          wseq = 0;
    int          done_seq = 0;
    int          last_upd_seq = 0;
    int          done_cnt = 0;
    logic        pl_we = 1'b0;
    int          pl_idx = 0;
    logic [31:0] pl_val = '0;

    logic [31:0] exp_mem [0:NB-1] = '{default: '0};
    logic [31:0] exp_clamp = '0;

    always #5 clk = ~clk;

    histogram_bram_scheduler #(
        .NUM_BINS   (NB),
        .FIFO_DEPTH (4),
        .DONE_VALUE (32'hffffffff)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .upd_valid    (upd_valid),
        .upd_ready    (upd_ready),
        .upd_bin      (upd_bin),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .finish       (finish),
        .done_written (done_written),
        .clamp_count  (clamp_count),
        .we           (we),
        .en           (en),
        .addr         (addr),
        .di           (di),
        .dout         (dout_r)
    );

    always @(posedge clk) begin
        if (pl_we) mem[pl_idx] = pl_val;
        if (en) begin
            if (we == 4'hf) begin
                if (addr[31:2] <= 30'(NB)) begin
                    mem[addr[12:2]] = di;
                    wr_cnt[addr[12:2]]++;
                end
                wseq++;
                if (addr == 32'h1000) begin
                    done_cnt++;
                    done_seq = wseq;
                end else begin
                    last_upd_seq = wseq;
                end
            end else if (addr[31:2] <= 30'(NB)) begin
                dout_r <= mem[addr[12:2]];
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_idx = idx; pl_val = v;
        @(posedge clk);
        #1 pl_we = 1'b0;
        exp_mem[idx] = v;
    endtask

    task automatic push(input logic [31:0] b, input bit model);
        int n = 0;
        int idx;
        @(negedge clk);
        upd_valid = 1'b1; upd_bin = b;
        while (!upd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!upd_ready) begin
            total++; bad++;
            $display("FAIL push_timeout bin=%0d ready=%b required=1", b, upd_ready);
        end else begin
            idx = (b >= NB) ? NB - 1 : int'(b);
            if (b >= NB) exp_clamp = exp_clamp + 1;
            if (model && exp_mem[idx] != 32'hffffffff)
                exp_mem[idx] = exp_mem[idx] + 1;
        end
        @(posedge clk);
        #1 upd_valid = 1'b0;
    endtask

    task automatic pulse_finish();
        @(negedge clk); finish = 1'b1;
        @(posedge clk); #1 finish = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({we, en, addr, di} !== '0) begin
            bad++;
            $display("FAIL reset_bram we=%h en=%b addr=%h di=%h required 0", we, en, addr, di);
        end
        total++;
        if (upd_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b required=0", upd_ready);
        end
        total++;
        if (clear_busy !== 0 || done_written !== 0 || clamp_count !== 0) begin
            bad++;
            $display("FAIL reset_status busy=%b done=%b clamp=%0d required 0/0/0", clear_busy, done_written, clamp_count);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (upd_ready !== 1'b1) begin
            bad++; $display("FAIL release_ready got=%b required=1", upd_ready);
        end
    endtask

    task automatic test_single();
        preload(5, 32'd7);
        push(32'd5, 1);
        @(negedge clk);
        total++;
        if (en !== 1'b0) begin
            bad++; $display("FAIL single_idle en=%b required=0", en);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if (en !== 1'b1 || we !== 4'h0 || addr !== 32'h14 || upd_ready !== 1'b1) begin
                bad++;
                $display("FAIL single_read%0d en=%b we=%h addr=%h rdy=%b required 1/0/14/1", c, en, we, addr, upd_ready);
            end
        end
        @(negedge clk);
        total++;
        if (en !== 1'b1 || we !== 4'hf || addr !== 32'h14 || di !== 32'd8) begin
            bad++;
            $display("FAIL single_write en=%b we=%h addr=%h di=%0d required 1/f/14/8", en, we, addr, di);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt[3];
        for (int i = 0; i < 5; i++) push(32'd3, 1);
        @(negedge clk);
        total++;
        if (upd_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_full_ready got=%b required=0", upd_ready);
        end
        repeat (30) @(negedge clk);
        total++;
        if (mem[3] !== exp_mem[3]) begin
            bad++; $display("FAIL b2b_word got=%0d required=%0d", mem[3], exp_mem[3]);
        end
        total++;
        if (wr_cnt[3] - w0 != 5) begin
            bad++; $display("FAIL b2b_writes got=%0d required=5", wr_cnt[3] - w0);
        end
    endtask

    task automatic test_clamp();
        preload(NB - 1, 32'd100);
        preload(7, 32'hffffffff);
        push(32'd5000, 1);
        push(32'd7, 1);
        repeat (20) @(negedge clk);
        total++;
        if (mem[NB-1] !== exp_mem[NB-1]) begin
            bad++; $display("FAIL clamp_word got=%0d required=%0d", mem[NB-1], exp_mem[NB-1]);
        end
        total++;
        if (clamp_count !== exp_clamp) begin
            bad++; $display("FAIL clamp_count got=%0d required=%0d", clamp_count, exp_clamp);
        end
        total++;
        if (mem[7] !== 32'hffffffff) begin
            bad++; $display("FAIL saturate got=%h required=ffffffff", mem[7]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++)
            preload(i, (i % 5 == 0) ? 32'hffffffff - 32'(i % 2) : $urandom_range(0, 1000));
        for (int i = 0; i < 60; i++) begin
            logic [31:0] b;
            if ($urandom_range(0, 7) == 0) b = $urandom_range(NB, 200000);
            else b = $urandom_range(0, 15);
            push(b, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            total++;
            if (mem[i] !== exp_mem[i]) begin
                bad++; $display("FAIL rand_bin%0d got=%0d required=%0d", i, mem[i], exp_mem[i]);
            end
        end
        total++;
        if (clamp_count !== exp_clamp) begin
            bad++; $display("FAIL rand_clamp got=%0d required=%0d", clamp_count, exp_clamp);
        end
    endtask

    task automatic test_finish();
        int n = 0;
        int d0 = done_cnt;
        push(32'd20, 1);
        push(32'd21, 1);
        pulse_finish();
        while (!done_written && n < 100) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        total++;
        if (done_written !== 1'b1) begin
            bad++; $display("FAIL finish_timeout done=%b required=1", done_written);
        end
        total++;
        if (mem[20] !== exp_mem[20] || mem[21] !== exp_mem[21]) begin
            bad++;
            $display("FAIL finish_drain w20=%0d w21=%0d required %0d/%0d", mem[20], mem[21], exp_mem[20], exp_mem[21]);
        end
        total++;
        if (done_cnt - d0 != 1 || mem[NB] !== 32'hffffffff || done_seq <= last_upd_seq) begin
            bad++;
            $display("FAIL finish_marker writes=%0d val=%h order=%0d/%0d required 1/ffffffff/after", done_cnt - d0, mem[NB], done_seq, last_upd_seq);
        end
        upd_valid = 1'b1; upd_bin = 32'd2;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++;
            if (upd_ready !== 1'b0) begin
                bad++; $display("FAIL finished_ready got=%b required=0", upd_ready);
            end
        end
        upd_valid = 1'b0;
        pulse_finish();
        repeat (8) @(negedge clk);
        total++;
        if (done_cnt - d0 != 1) begin
            bad++; $display("FAIL finish_ignored writes=%0d required=1", done_cnt - d0);
        end
    endtask

    task automatic test_clear();
        @(negedge clk); clear_start = 1'b1;
        @(posedge clk); #1 clear_start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            total++;
            if (clear_busy !== 1'b1 || en !== 1'b1 || we !== 4'hf || addr !== 32'(i * 4) || di !== 0 || upd_ready !== 1'b0) begin
                bad++;
                $display("FAIL clear_step%0d busy=%b we=%h addr=%h di=%h rdy=%b required 1/f/%h/0/0", i, clear_busy, we, addr, di, upd_ready, 32'(i * 4));
                break;
            end
        end
        @(negedge clk);
        total++;
        if (clear_busy !== 1'b0 || done_written !== 1'b0 || upd_ready !== 1'b1) begin
            bad++;
            $display("FAIL clear_end busy=%b done=%b rdy=%b required 0/0/1", clear_busy, done_written, upd_ready);
        end
        for (int i = 0; i < NB; i++) exp_mem[i] = '0;
        for (int i = 0; i < NB; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                total++; bad++;
                $display("FAIL clear_word%0d got=%h required=0", i, mem[i]);
                break;
            end
        end
    endtask

    task automatic test_reset_mid();
        int w0 = wr_cnt[9];
        push(32'd9, 0);
        repeat (3) @(negedge clk);
        total++;
        if (en !== 1'b1 || we !== 4'h0 || addr !== 32'h24) begin
            bad++; $display("FAIL mid_cap en=%b we=%h addr=%h required 1/0/24", en, we, addr);
        end
        #1 reset_n = 1'b0;
        #1;
        total++;
        if ({we, en, addr, di} !== '0 || upd_ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset we=%h en=%b addr=%h di=%h rdy=%b required 0", we, en, addr, di, upd_ready);
        end
        exp_clamp = '0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (upd_ready !== 1'b1) begin
            bad++; $display("FAIL mid_ready got=%b required=1", upd_ready);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (en !== 1'b0) begin
                bad++; $display("FAIL mid_quiet%0d en=%b required=0", c, en);
            end
        end
        total++;
        if (wr_cnt[9] != w0 || mem[9] !== exp_mem[9] || clamp_count !== exp_clamp) begin
            bad++;
            $display("FAIL mid_nowrite writes=%0d word=%0d clamp=%0d required %0d/%0d/0", wr_cnt[9] - w0, mem[9], clamp_count, 0, exp_mem[9]);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_clamp();
        test_random();
        test_finish();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
